fifo_flush_reader: RTL and testbench



---
 rtl/fifo_flush_reader.sv | 126 ++++++++++++
 tb/tb_fifo_flush_reader.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_flush_reader.sv
// Flush initiator for the nibble FIFO: requests a flush, captures and acknowledges
// the packed 32-bit word, strips top padding and streams nibbles oldest first.
module fifo_flush_reader #(
    parameter int STRIP_PAD  = 1,
    parameter int WAIT_MAX   = 15,
    parameter int GAP_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable_i,
    input  logic        fifo_empty_i,
    output logic        fifo_flush_o,
    input  logic        fifo_data_avail_i,
    input  logic [31:0] fifo_rd_data_i,
    output logic        fifo_rd_valid_o,
    output logic        nib_valid_o,
    output logic [3:0]  nib_data_o,
    input  logic        nib_ready_i,
    output logic        busy_o,
    output logic        timeout_o,
    output logic [15:0] word_count_o
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] REQ   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] GAP   = 2'd3;

    localparam logic [7:0]  WAIT_LAST = 8'(WAIT_MAX - 1);
    localparam logic [15:0] GAP_LAST  = 16'(GAP_CYCLES - 1);

    logic [1:0]  state;
    logic [31:0] word_q;
    logic [2:0]  idx;
    logic [7:0]  wait_cnt;
    logic [15:0] gap_cnt;
    logic [3:0]  emit_cnt;
    logic        last_nib;

    // Number of nibbles left after dropping the contiguous 0xC run at the top.
    function automatic logic [3:0] pad_strip_count(input logic [31:0] w);
        logic [3:0] n;
        logic       stop;
        n    = 4'd8;
        stop = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            if (!stop && (w[i*4 +: 4] == 4'hC)) begin
                n = n - 4'd1;
            end else begin
                stop = 1'b1;
            end
        end
        return n;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign emit_cnt = (STRIP_PAD != 0) ? pad_strip_count(word_q) : 4'd8;
    assign last_nib = ({1'b0, idx} == (emit_cnt - 4'd1));

    assign fifo_flush_o    = (state == REQ);
    assign fifo_rd_valid_o = (state == REQ) && fifo_data_avail_i;
    assign nib_valid_o     = (state == DRAIN) && (emit_cnt != 4'd0);
    assign nib_data_o      = nib_valid_o ? word_q[{idx, 2'b00} +: 4] : 4'h0;
    assign busy_o          = (state != IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            word_q       <= '0;
            idx          <= '0;
            wait_cnt     <= '0;
            gap_cnt      <= '0;
            timeout_o    <= 1'b0;
            word_count_o <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (enable_i && !fifo_empty_i) begin
                        wait_cnt <= '0;
                        state    <= REQ;
                    end
                end
                REQ: begin
                    if (fifo_data_avail_i) begin
                        word_q       <= fifo_rd_data_i;
                        word_count_o <= sat_inc16(word_count_o);
                        idx          <= '0;
                        state        <= DRAIN;
                    end else if (wait_cnt == WAIT_LAST) begin
                        timeout_o <= 1'b1;
                        gap_cnt   <= '0;
                        state     <= GAP;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                DRAIN: begin
                    // An all-pad word has nothing to emit and falls straight through.
                    if (emit_cnt == 4'd0) begin
                        gap_cnt <= '0;
                        state   <= GAP;
                    end else if (nib_ready_i) begin
                        if (last_nib) begin
                            gap_cnt <= '0;
                            state   <= GAP;
                        end else begin
                            idx <= idx + 3'd1;
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_flush_reader.sv
// Directed bench for fifo_flush_reader: drives flush transactions, models the
// expected nibble stream in a queue and checks every accepted nibble against it.
module tb_fifo_flush_reader;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        fifo_empty;
    logic        fifo_flush;
    logic        fifo_data_avail;
    logic [31:0] fifo_rd_data;
    logic        fifo_rd_valid;
    logic        nib_valid;
    logic [3:0]  nib_data;
    logic        nib_ready;
    logic        busy;
    logic        timeout;
    logic [15:0] word_count;

    int checks = 0;
    int errors = 0;

    logic [4:0] exp_q[$];

    int cyc = 0;
    int flush_hi = 0, rd_pulses = 0, valid_seen = 0, gap_seen = 0, xfer = 0;
    int b_flush, b_rd, b_valid, b_gap, b_xfer;
    int first_xfer_cyc = 0, last_xfer_cyc = 0;
    bit first_pending = 1'b0;
    bit hold_pending = 1'b0;
    logic [3:0] held;
    logic [15:0] wc_before;

    always #5 clk = ~clk;

    fifo_flush_reader dut (
        .clk               (clk),
        .reset             (reset),
        .enable_i          (enable),
        .fifo_empty_i      (fifo_empty),
        .fifo_flush_o      (fifo_flush),
        .fifo_data_avail_i (fifo_data_avail),
        .fifo_rd_data_i    (fifo_rd_data),
        .fifo_rd_valid_o   (fifo_rd_valid),
        .nib_valid_o       (nib_valid),
        .nib_data_o        (nib_data),
        .nib_ready_i       (nib_ready),
        .busy_o            (busy),
        .timeout_o         (timeout),
        .word_count_o      (word_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference unpacking: trim the 0xC run from the top, emit the rest oldest first.
    task automatic push_model(input logic [31:0] w);
        int top = 8;
        while (top > 0 && w[(top-1)*4 +: 4] == 4'hC) top--;
        for (int i = 0; i < top; i++) exp_q.push_back({1'b0, w[i*4 +: 4]});
    endtask

    task automatic sample();
        logic [4:0] e;
        cyc++;
        if (!reset) begin
            hold_pending = 1'b0;
        end else begin
            if (fifo_flush) flush_hi++;
            if (fifo_rd_valid) rd_pulses++;
            if (nib_valid) valid_seen++;
            if (busy && !fifo_flush && !nib_valid) gap_seen++;
            if (hold_pending) begin
                check("hold_valid", nib_valid, 1);
                check("hold_data", nib_data, held);
            end
            if (nib_valid && nib_ready) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 5'h10;
                check("nibble", {1'b0, nib_data}, e);
                xfer++;
                last_xfer_cyc = cyc;
                if (first_pending) begin
                    first_xfer_cyc = cyc;
                    first_pending  = 1'b0;
                end
            end
            hold_pending = nib_valid && !nib_ready;
            held         = nib_data;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
    endtask

    task automatic snap();
        b_flush = flush_hi; b_rd = rd_pulses; b_valid = valid_seen;
        b_gap = gap_seen; b_xfer = xfer; wc_before = word_count;
        first_pending = 1'b1;
    endtask

    task automatic wait_flush();
        int n = 0;
        while (!fifo_flush && n < 10) begin
            tick();
            n++;
        end
        check("flush_rise", fifo_flush, 1);
    endtask

    task automatic run_word(input logic [31:0] w, input int delay, input bit toggle);
        int n = 0;
        snap();
        nib_ready  = 1'b1;
        enable     = 1'b1;
        fifo_empty = 1'b0;
        wait_flush();
        enable     = 1'b0;
        fifo_empty = 1'b1;
        repeat (delay - 1) tick();
        fifo_data_avail = 1'b1;
        fifo_rd_data    = w;
        push_model(w);
        tick();
        fifo_data_avail = 1'b0;
        fifo_rd_data    = $urandom;
        while (busy && n < 200) begin
            if (toggle) nib_ready = ~nib_ready;
            tick();
            n++;
        end
        check("drain_done", busy, 0);
        check("queue_empty", exp_q.size(), 0);
        nib_ready = 1'b1;
    endtask

    initial begin
        int n;
        reset = 1'b0; enable = 1'b0; fifo_empty = 1'b1;
        fifo_data_avail = 1'b0; fifo_rd_data = '0; nib_ready = 1'b0;
        #1;
        tick();
        tick();
        check("rst_flush", fifo_flush, 0);
        check("rst_rd_valid", fifo_rd_valid, 0);
        check("rst_nib_valid", nib_valid, 0);
        check("rst_nib_data", nib_data, 0);
        check("rst_busy", busy, 0);
        check("rst_timeout", timeout, 0);
        check("rst_word_count", word_count, 0);
        reset = 1'b1;
        tick();

        // Reset asserted in the middle of a drain, with idx at 3
        snap();
        nib_ready = 1'b1; enable = 1'b1; fifo_empty = 1'b0;
        wait_flush();
        enable = 1'b0; fifo_empty = 1'b1;
        fifo_data_avail = 1'b1; fifo_rd_data = 32'h76543210;
        push_model(32'h76543210);
        tick();
        fifo_data_avail = 1'b0;
        n = 0;
        while ((xfer - b_xfer) < 3 && n < 20) begin
            tick();
            n++;
        end
        check("t1_xfers_before_reset", xfer - b_xfer, 3);
        reset = 1'b0;
        tick();
        check("t1_flush", fifo_flush, 0);
        check("t1_rd_valid", fifo_rd_valid, 0);
        check("t1_nib_valid", nib_valid, 0);
        check("t1_nib_data", nib_data, 0);
        check("t1_busy", busy, 0);
        check("t1_word_count", word_count, 0);
        exp_q.delete();
        reset = 1'b1; enable = 1'b1; fifo_empty = 1'b1;
        snap();
        repeat (5) tick();
        check("t1_flush_stays_low", flush_hi - b_flush, 0);
        check("t1_idle", busy, 0);
        enable = 1'b0;

        // Padded word, ready high, avail three cycles into the request
        run_word(32'hCCCC4321, 3, 1'b0);
        check("t2_req_cycles", flush_hi - b_flush, 3);
        check("t2_rd_pulse", rd_pulses - b_rd, 1);
        check("t2_xfers", xfer - b_xfer, 4);
        check("t2_back_to_back", last_xfer_cyc - first_xfer_cyc, 3);
        check("t2_gap", gap_seen - b_gap, 2);
        check("t2_word_count", word_count, 1);

        // Full word with ready toggling
        run_word(32'h76543210, 1, 1'b1);
        check("t3_xfers", xfer - b_xfer, 8);
        check("t3_rd_pulse", rd_pulses - b_rd, 1);
        check("t3_word_count", word_count, 2);

        // All-pad word: nothing emitted
        run_word(32'hCCCCCCCC, 2, 1'b0);
        check("t4_no_valid", valid_seen - b_valid, 0);
        check("t4_drain_plus_gap", gap_seen - b_gap, 3);
        check("t4_word_count", word_count, 3);
        check("t4_idle", busy, 0);

        // Internal 0xC nibbles below the top data nibble are kept
        run_word(32'h1C2CCCCC, 1, 1'b0);
        check("t5_xfers", xfer - b_xfer, 8);
        check("t5_word_count", word_count, 4);

        // No avail ever: timeout after WAIT_MAX request cycles
        snap();
        enable = 1'b1; fifo_empty = 1'b0;
        wait_flush();
        enable = 1'b0; fifo_empty = 1'b1;
        n = 0;
        while (fifo_flush && n < 40) begin
            tick();
            n++;
        end
        check("t6_flush_dropped", fifo_flush, 0);
        check("t6_req_cycles", flush_hi - b_flush, 15);
        check("t6_timeout", timeout, 1);
        n = 0;
        while (busy && n < 20) begin
            tick();
            n++;
        end
        check("t6_gap", gap_seen - b_gap, 2);
        check("t6_no_rd_pulse", rd_pulses - b_rd, 0);
        check("t6_word_count", word_count, wc_before);

        // Avail outside REQ is ignored; timeout stays set
        snap();
        fifo_data_avail = 1'b1; fifo_rd_data = 32'h00000005;
        repeat (3) tick();
        fifo_data_avail = 1'b0;
        check("stray_avail_rd", rd_pulses - b_rd, 0);
        check("stray_avail_count", word_count, wc_before);
        check("stray_avail_idle", busy, 0);
        check("timeout_sticky", timeout, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
